biriscv_v_writeback: RTL and testbench
======================================

BIRISCV_V_WRITEBACK -- requirements
Module: biriscv_v_writeback

Interface
REQ-001 The block SHALL provide parameter VLEN, default 128, meaning vector register width in bits.
REQ-002 The block SHALL provide parameter ELEN, default 32, meaning element width in bits; NUM_ELEM = VLEN/ELEN (default 4).
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk_i  input  1  rising-edge clock.
REQ-005 rst_ni  input  1  reset; asynchronous assertion, active low.
REQ-006 alu_valid_i  input  1  vector ALU result present this cycle.
REQ-007 alu_ready_o  output  1  writeback can accept a result this cycle.
REQ-008 alu_vd_idx_i  input  5  destination vector register index.
REQ-009 alu_result_i  input  VLEN  raw vector ALU result.
REQ-010 alu_vm_i  input  1  instruction vm bit; 1 means unmasked.
REQ-011 alu_vmask_i  input  VLEN  v0 mask operand; the bit for element i is bit i*ELEN.
REQ-012 alu_vd_old_i  input  VLEN  prior contents of vd, used for the mask-undisturbed merge.
REQ-013 flush_i  input  1  synchronous pipeline flush.
REQ-014 vrf_wr_en_o  output  1  vector register file write request.
REQ-015 vrf_wr_idx_o  output  5  write index.
REQ-016 vrf_wr_data_o  output  VLEN  write data.
REQ-017 vrf_ready_i  input  1  register file accepts the write this cycle.
REQ-018 pending_o  output  32  bitmap of vd indices held in the block, for scoreboard stalls.
REQ-019 complete_o  output  1  one-cycle pulse per retired write.
REQ-020 complete_idx_o  output  5  index of the retired write.

Function
REQ-021 Push SHALL occur on a clock edge where alu_valid_i & alu_ready_o & !flush_i.
REQ-022 alu_ready_o SHALL equal (count < 2), decoded from registered occupancy only, with no combinational path from vrf_ready_i.
REQ-023 On push, each element i SHALL be stored as alu_result_i element i if (alu_vm_i | alu_vmask_i[i*ELEN]), else as alu_vd_old_i element i.
REQ-024 Storage SHALL be a 2-entry FIFO (fields: idx, data) with 1-bit read and write pointers that wrap 1->0, plus a 2-bit count (0..2).
REQ-025 vrf_wr_en_o SHALL equal (count != 0); vrf_wr_idx_o and vrf_wr_data_o SHALL show the head entry, and SHALL be zero when the FIFO is empty.
REQ-026 Pop SHALL occur on an edge where vrf_wr_en_o & vrf_ready_i & !flush_i; head outputs SHALL stay stable while vrf_ready_i is low.
REQ-027 Latency: a result pushed at edge N SHALL appear on vrf_wr_en_o in the cycle after N at the earliest; there is no same-cycle bypass.
REQ-028 Push and pop in the same cycle (count 1) SHALL leave count unchanged and advance both pointers.
REQ-029 At count 2, alu_ready_o SHALL be 0 and alu_valid_i SHALL be ignored, including in a cycle where a pop occurs.
REQ-030 complete_o SHALL be a registered pulse, high for the one cycle after each pop, with complete_idx_o equal to the popped idx; otherwise complete_idx_o SHALL be 0.
REQ-031 pending_o SHALL be the combinational OR of one-hot(idx) over valid entries; a bit shared by two entries SHALL clear only when both have drained.
REQ-032 flush_i SHALL, at the next edge, empty the FIFO (count and both pointers to 0) and suppress the push, the pop, and complete_o for that edge.

Reset
REQ-033 While rst_ni is low, and immediately on its assertion: count = 0, pointers = 0, alu_ready_o = 1, vrf_wr_en_o = 0, pending_o = 0, complete_o = 0, complete_idx_o = 0.
REQ-034 Reset asserted mid-operation SHALL discard all entries with no write and no complete pulse.
REQ-035 Entry data storage need not be reset, but no output SHALL expose it while the FIFO is empty.

Verification
REQ-036 Masked merge: VLEN=128, vm=0, vmask element bits {1,0,1,0}, result 0xAAAA_AAAA per element, old 0x1111_1111 per element, vd=5 -> vrf_wr_data_o elements = {AAAAAAAA, 11111111, AAAAAAAA, 11111111}, idx 5, pending_o = 0x20.
REQ-037 Backpressure: vrf_ready_i=0 while pushing vd=3 then vd=7 -> count 2, alu_ready_o=0, a third valid is dropped, head stays idx 3; release ready -> writes 3 then 7 on consecutive cycles, complete_o pulses with idx 3 then 7.
REQ-038 Streaming: valid every cycle with vrf_ready_i=1 -> one write per cycle, count stays at 1, alu_ready_o stays 1.
REQ-039 Same index twice: push vd=4 twice, then pop once -> pending_o[4] stays 1, and clears after the second pop.
REQ-040 Flush: count 2, flush_i=1 together with alu_valid_i=1 -> next cycle count 0, vrf_wr_en_o=0, no complete_o, pending_o=0.
REQ-041 Async reset: assert rst_ni low between clock edges at count 2 -> outputs go to their reset values immediately, with no clock edge needed.

Source files
------------

// File: rtl/biriscv_v_writeback.sv
// Vector writeback stage: masks ALU results against old vd, queues them, and writes them to the VRF.
// Latency: at least one cycle from accept to VRF write request; there is no same-cycle bypass.
// Backpressure: a 2-entry queue absorbs VRF stalls; alu_ready_o comes only from registered occupancy.
module biriscv_v_writeback #(
  parameter int VLEN = 128,
  parameter int ELEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            alu_valid_i,
  output logic            alu_ready_o,
  input  logic [4:0]      alu_vd_idx_i,
  input  logic [VLEN-1:0] alu_result_i,
  input  logic            alu_vm_i,
  input  logic [VLEN-1:0] alu_vmask_i,
  input  logic [VLEN-1:0] alu_vd_old_i,
  input  logic            flush_i,
  output logic            vrf_wr_en_o,
  output logic [4:0]      vrf_wr_idx_o,
  output logic [VLEN-1:0] vrf_wr_data_o,
  input  logic            vrf_ready_i,
  output logic [31:0]     pending_o,
  output logic            complete_o,
  output logic [4:0]      complete_idx_o
);

  localparam int NUM_ELEM = VLEN / ELEN;

  logic [4:0]      idx_q  [2];
  logic [4:0]      idx_d  [2];
  logic [VLEN-1:0] data_q [2];
  logic [VLEN-1:0] data_d [2];
  logic [1:0]      count_q, count_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic            wr_ptr_q, wr_ptr_d;
  logic            complete_q, complete_d;
  logic [4:0]      complete_idx_q, complete_idx_d;

  logic [VLEN-1:0] merged;
  logic            push;
  logic            pop;

  // Mask-undisturbed merge: inactive elements keep the old vd contents.
  always_comb begin
    merged = '0;
    for (int i = 0; i < NUM_ELEM; i++) begin
      merged[i*ELEN +: ELEN] = (alu_vm_i | alu_vmask_i[i*ELEN]) ? alu_result_i[i*ELEN +: ELEN]
                                                                : alu_vd_old_i[i*ELEN +: ELEN];
    end
  end

  assign alu_ready_o = (count_q != 2'd2);
  assign push        = alu_valid_i & alu_ready_o & ~flush_i;
  assign pop         = (count_q != 2'd0) & vrf_ready_i & ~flush_i;

  // Next-state for queue storage, pointers, occupancy and the retire pulse.
  always_comb begin
    idx_d          = idx_q;
    data_d         = data_q;
    count_d        = count_q;
    rd_ptr_d       = rd_ptr_q;
    wr_ptr_d       = wr_ptr_q;
    complete_d     = 1'b0;
    complete_idx_d = 5'd0;
    if (flush_i) begin
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      if (push) begin
        idx_d[wr_ptr_q]  = alu_vd_idx_i;
        data_d[wr_ptr_q] = merged;
        wr_ptr_d         = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d       = rd_ptr_q + 1'b1;
        complete_d     = 1'b1;
        complete_idx_d = idx_q[rd_ptr_q];
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers; reset empties the queue and kills any pending retire pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q[0]       <= 5'd0;
      idx_q[1]       <= 5'd0;
      data_q[0]      <= '0;
      data_q[1]      <= '0;
      count_q        <= 2'd0;
      rd_ptr_q       <= 1'b0;
      wr_ptr_q       <= 1'b0;
      complete_q     <= 1'b0;
      complete_idx_q <= 5'd0;
    end else begin
      idx_q[0]       <= idx_d[0];
      idx_q[1]       <= idx_d[1];
      data_q[0]      <= data_d[0];
      data_q[1]      <= data_d[1];
      count_q        <= count_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      complete_q     <= complete_d;
      complete_idx_q <= complete_idx_d;
    end
  end

  // Head presentation; stale storage is hidden while empty.
  always_comb begin
    vrf_wr_en_o   = (count_q != 2'd0);
    vrf_wr_idx_o  = vrf_wr_en_o ? idx_q[rd_ptr_q]  : 5'd0;
    vrf_wr_data_o = vrf_wr_en_o ? data_q[rd_ptr_q] : '0;
  end

  // Scoreboard bitmap: OR of one-hot indices over every occupied entry.
  always_comb begin
    pending_o = 32'd0;
    if (count_q != 2'd0) pending_o[idx_q[rd_ptr_q]] = 1'b1;
    if (count_q == 2'd2) pending_o[idx_q[~rd_ptr_q]] = 1'b1;
  end

  assign complete_o     = complete_q;
  assign complete_idx_o = complete_idx_q;

endmodule

// File: tb/tb_biriscv_v_writeback.sv
module tb_biriscv_v_writeback;

  localparam int VLEN = 128;
  localparam int ELEN = 32;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            alu_valid_i = 1'b0;
  logic            alu_ready_o;
  logic [4:0]      alu_vd_idx_i = '0;
  logic [VLEN-1:0] alu_result_i = '0;
  logic            alu_vm_i = 1'b1;
  logic [VLEN-1:0] alu_vmask_i = '0;
  logic [VLEN-1:0] alu_vd_old_i = '0;
  logic            flush_i = 1'b0;
  logic            vrf_wr_en_o;
  logic [4:0]      vrf_wr_idx_o;
  logic [VLEN-1:0] vrf_wr_data_o;
  logic            vrf_ready_i = 1'b0;
  logic [31:0]     pending_o;
  logic            complete_o;
  logic [4:0]      complete_idx_o;

  biriscv_v_writeback #(.VLEN(VLEN), .ELEN(ELEN)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .alu_valid_i(alu_valid_i), .alu_ready_o(alu_ready_o),
    .alu_vd_idx_i(alu_vd_idx_i), .alu_result_i(alu_result_i),
    .alu_vm_i(alu_vm_i), .alu_vmask_i(alu_vmask_i), .alu_vd_old_i(alu_vd_old_i),
    .flush_i(flush_i),
    .vrf_wr_en_o(vrf_wr_en_o), .vrf_wr_idx_o(vrf_wr_idx_o), .vrf_wr_data_o(vrf_wr_data_o),
    .vrf_ready_i(vrf_ready_i), .pending_o(pending_o),
    .complete_o(complete_o), .complete_idx_o(complete_idx_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [VLEN-1:0] act, input logic [VLEN-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of at most two pending writes.
  typedef struct packed {
    logic [4:0]      idx;
    logic [VLEN-1:0] data;
  } ent_t;

  ent_t       mq[$];
  logic       m_cpl = 1'b0;
  logic [4:0] m_cpl_idx = '0;

  function automatic logic [VLEN-1:0] masked(input logic [VLEN-1:0] res, input logic vm,
                                             input logic [VLEN-1:0] vmask, input logic [VLEN-1:0] old);
    logic [VLEN-1:0] r;
    for (int e = 0; e < VLEN / ELEN; e++) begin
      if (vm || vmask[e*ELEN]) r[e*ELEN +: ELEN] = res[e*ELEN +: ELEN];
      else                     r[e*ELEN +: ELEN] = old[e*ELEN +: ELEN];
    end
    return r;
  endfunction

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mq.delete();
      m_cpl = 1'b0;
      m_cpl_idx = '0;
    end else begin
      bit can_take;
      ent_t e;
      m_cpl = 1'b0;
      m_cpl_idx = '0;
      if (flush_i) begin
        mq.delete();
      end else begin
        can_take = (mq.size() < 2);
        if (mq.size() != 0 && vrf_ready_i) begin
          m_cpl = 1'b1;
          m_cpl_idx = mq[0].idx;
          void'(mq.pop_front());
        end
        if (alu_valid_i && can_take) begin
          e.idx = alu_vd_idx_i;
          e.data = masked(alu_result_i, alu_vm_i, alu_vmask_i, alu_vd_old_i);
          mq.push_back(e);
        end
      end
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk_i) begin
    logic [31:0]     exp_pend;
    logic [4:0]      exp_idx;
    logic [VLEN-1:0] exp_data;
    exp_pend = '0;
    exp_idx  = '0;
    exp_data = '0;
    foreach (mq[k]) exp_pend[mq[k].idx] = 1'b1;
    if (mq.size() != 0) begin
      exp_idx  = mq[0].idx;
      exp_data = mq[0].data;
    end
    check("alu_ready", VLEN'(alu_ready_o), VLEN'(mq.size() < 2));
    check("wr_en", VLEN'(vrf_wr_en_o), VLEN'(mq.size() != 0));
    check("wr_idx", VLEN'(vrf_wr_idx_o), VLEN'(exp_idx));
    check("wr_data", vrf_wr_data_o, exp_data);
    check("pending", VLEN'(pending_o), VLEN'(exp_pend));
    check("complete", VLEN'(complete_o), VLEN'(m_cpl));
    check("complete_idx", VLEN'(complete_idx_o), VLEN'(m_cpl_idx));
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] idx, input logic [VLEN-1:0] res);
    alu_valid_i  = v;
    alu_vd_idx_i = idx;
    alu_result_i = res;
  endtask

  initial begin
    #2;
    check("rst_ready", VLEN'(alu_ready_o), VLEN'(1));
    check("rst_wr_en", VLEN'(vrf_wr_en_o), VLEN'(0));
    check("rst_pending", VLEN'(pending_o), VLEN'(0));
    check("rst_complete", VLEN'(complete_o), VLEN'(0));
    @(posedge clk_i);
    #3 rst_ni = 1'b1;
    step();

    // Masked merge: element 0 and 2 active, 1 and 3 keep old.
    vrf_ready_i  = 1'b0;
    alu_vm_i     = 1'b0;
    alu_vmask_i  = 128'h00000000_00000001_00000000_00000001;
    alu_vd_old_i = {4{32'h1111_1111}};
    drive(1'b1, 5'd5, {4{32'hAAAA_AAAA}});
    step();
    drive(1'b0, 5'd0, '0);
    alu_vm_i = 1'b1;
    check("merge_data", vrf_wr_data_o, 128'h11111111_AAAAAAAA_11111111_AAAAAAAA);
    check("merge_idx", VLEN'(vrf_wr_idx_o), VLEN'(5));
    check("merge_pending", VLEN'(pending_o), VLEN'(32'h20));
    vrf_ready_i = 1'b1;
    step();
    check("merge_cpl_idx", VLEN'(complete_idx_o), VLEN'(5));
    step();

    // Backpressure: fill with 3 and 7, third push dropped.
    vrf_ready_i = 1'b0;
    drive(1'b1, 5'd3, 128'h3333);
    step();
    drive(1'b1, 5'd7, 128'h7777);
    step();
    check("bp_ready_full", VLEN'(alu_ready_o), VLEN'(0));
    drive(1'b1, 5'd9, 128'h9999);
    step();
    check("bp_head", VLEN'(vrf_wr_idx_o), VLEN'(3));
    check("bp_pending", VLEN'(pending_o), VLEN'(32'h88));
    drive(1'b0, 5'd0, '0);
    vrf_ready_i = 1'b1;
    step();
    check("bp_cpl1", VLEN'({complete_o, complete_idx_o}), VLEN'({1'b1, 5'd3}));
    check("bp_head2", VLEN'(vrf_wr_idx_o), VLEN'(7));
    step();
    check("bp_cpl2", VLEN'({complete_o, complete_idx_o}), VLEN'({1'b1, 5'd7}));
    check("bp_empty", VLEN'(vrf_wr_en_o), VLEN'(0));
    step();

    // Streaming: one push and one pop per cycle.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 5'(10 + i), {4{32'(i * 32'h0101_0101)}});
      step();
      check("stream_ready", VLEN'(alu_ready_o), VLEN'(1));
    end
    drive(1'b0, 5'd0, '0);
    step();
    step();

    // Same index twice: bit must survive the first pop.
    vrf_ready_i = 1'b0;
    drive(1'b1, 5'd4, 128'h44);
    step();
    drive(1'b1, 5'd4, 128'h45);
    step();
    drive(1'b0, 5'd0, '0);
    vrf_ready_i = 1'b1;
    step();
    check("same_pend1", VLEN'(pending_o), VLEN'(32'h10));
    step();
    check("same_pend0", VLEN'(pending_o), VLEN'(0));
    step();

    // Flush at full occupancy, with a valid pushing at the same time.
    vrf_ready_i = 1'b0;
    drive(1'b1, 5'd1, 128'h1);
    step();
    drive(1'b1, 5'd2, 128'h2);
    step();
    drive(1'b1, 5'd8, 128'h8);
    flush_i = 1'b1;
    vrf_ready_i = 1'b1;
    step();
    flush_i = 1'b0;
    drive(1'b0, 5'd0, '0);
    check("flush_wr_en", VLEN'(vrf_wr_en_o), VLEN'(0));
    check("flush_cpl", VLEN'(complete_o), VLEN'(0));
    check("flush_pending", VLEN'(pending_o), VLEN'(0));
    step();

    // Asynchronous reset at full occupancy, between edges.
    vrf_ready_i = 1'b0;
    drive(1'b1, 5'd10, 128'hA);
    step();
    drive(1'b1, 5'd11, 128'hB);
    step();
    drive(1'b0, 5'd0, '0);
    #1 rst_ni = 1'b0;
    #1;
    check("arst_ready", VLEN'(alu_ready_o), VLEN'(1));
    check("arst_wr_en", VLEN'(vrf_wr_en_o), VLEN'(0));
    check("arst_pending", VLEN'(pending_o), VLEN'(0));
    check("arst_cpl", VLEN'({complete_o, complete_idx_o}), VLEN'(0));
    vrf_ready_i = 1'b1;
    step();
    check("arst_hold_wr_en", VLEN'(vrf_wr_en_o), VLEN'(0));
    rst_ni = 1'b1;
    step();
    check("arst_after_cpl", VLEN'(complete_o), VLEN'(0));
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
